// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - UART receive front end with runtime baud divisor and byte FIFO
module uart_rx_fifo #(
  parameter int FIFO_DEPTH = 4,
  parameter bit PARITY_EN  = 1'b0,
  parameter bit PARITY_ODD = 1'b0
) (
  input  logic                          io_clk,
  input  logic                          io_rst,
  input  logic [15:0]                   baud_div,
  input  logic                          rx_in,
  output logic [7:0]                    rx_data,
  output logic                          rx_valid,
  input  logic                          rx_ready,
  output logic                          frame_err,
  output logic                          parity_err,
  output logic                          overrun,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] FULL_LVL = (AW+1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, WAIT_HIGH} state_t;

  state_t      state, state_n;
  logic        rx_m, rx_s;
  logic [15:0] div_q, div_n, cnt, cnt_n;
  logic [2:0]  idx, idx_n;
  logic [7:0]  shift, shift_n;
  logic        par_bad, par_bad_n;
  logic        push, frame_n, parity_n;
  logic        at_sample, at_last;

  assign at_sample = (cnt == (div_q >> 1));
  assign at_last   = (cnt == div_q - 16'd1);
  assign busy      = (state != IDLE);

  always_ff @(posedge io_clk) begin
    if (io_rst) begin
      rx_m       <= 1'b1;
      rx_s       <= 1'b1;
      state      <= IDLE;
      div_q      <= 16'd4;
      cnt        <= 16'd0;
      idx        <= 3'd0;
      shift      <= 8'h00;
      par_bad    <= 1'b0;
      frame_err  <= 1'b0;
      parity_err <= 1'b0;
    end else begin
      rx_m       <= rx_in;
      rx_s       <= rx_m;
      state      <= state_n;
      div_q      <= div_n;
      cnt        <= cnt_n;
      idx        <= idx_n;
      shift      <= shift_n;
      par_bad    <= par_bad_n;
      frame_err  <= frame_n;
      parity_err <= parity_n;
    end
  end

  always_comb begin
    state_n   = state;
    div_n     = div_q;
    cnt_n     = cnt + 16'd1;
    idx_n     = idx;
    shift_n   = shift;
    par_bad_n = par_bad;
    push      = 1'b0;
    frame_n   = 1'b0;
    parity_n  = 1'b0;
    case (state)
      IDLE: begin
        cnt_n = 16'd0;
        if (!rx_s) begin
          state_n   = START;
          div_n     = (baud_div < 16'd4) ? 16'd4 : baud_div;
          par_bad_n = 1'b0;
        end
      end
      START: begin
        if (at_sample && rx_s) begin
          state_n = IDLE;
          cnt_n   = 16'd0;
        end else if (at_last) begin
          state_n = DATA;
          cnt_n   = 16'd0;
          idx_n   = 3'd0;
        end
      end
      DATA: begin
        if (at_sample) shift_n[idx] = rx_s;
        if (at_last) begin
          cnt_n = 16'd0;
          idx_n = idx + 3'd1;
          if (idx == 3'd7) state_n = PARITY_EN ? PARITY : STOP;
        end
      end
      PARITY: begin
        if (at_sample) par_bad_n = (rx_s != (PARITY_ODD ? ~^shift : ^shift));
        if (at_last) begin
          cnt_n   = 16'd0;
          state_n = STOP;
        end
      end
      STOP: begin
        // decide at mid stop bit so back-to-back frames are not missed
        if (at_sample) begin
          cnt_n = 16'd0;
          if (!rx_s) begin
            frame_n = 1'b1;
            state_n = WAIT_HIGH;
          end else if (par_bad) begin
            parity_n = 1'b1;
            state_n  = IDLE;
          end else begin
            push    = 1'b1;
            state_n = IDLE;
          end
        end
      end
      WAIT_HIGH: begin
        cnt_n = 16'd0;
        if (rx_s) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic          pop, full, do_push;

  assign rx_valid   = (count != '0);
  assign fifo_level = count;
  assign full       = (count == FULL_LVL);
  assign pop        = rx_valid && rx_ready;
  assign do_push    = push && (!full || pop);

  always_ff @(posedge io_clk) begin
    if (do_push) mem[wr_ptr] <= shift;
  end

  // rx_data is a registered copy of the head so it holds its value when empty
  always_ff @(posedge io_clk) begin
    if (io_rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      rx_data <= 8'h00;
      overrun <= 1'b0;
    end else begin
      overrun <= push && full && !pop;
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      if (do_push && !pop) count <= count + (AW+1)'(1);
      else if (pop && !do_push) count <= count - (AW+1)'(1);
      if (do_push && (count == '0 || (pop && count == (AW+1)'(1)))) rx_data <= shift;
      else if (pop && count > (AW+1)'(1)) rx_data <= mem[rd_ptr + AW'(1)];
    end
  end
endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb/tb_uart_rx_fifo.sv - randomized self-checking bench for uart_rx_fifo (8N1 and 8E1 instances)
module tb_uart_rx_fifo;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1;
  logic [15:0] baud_div = 16'd4;
  logic        rx_a = 1'b1, rx_b = 1'b1, ready_a = 1'b0, ready_b = 1'b0;
  logic [7:0]  data_a, data_b;
  logic        valid_a, valid_b, fe_a, fe_b, pe_a, pe_b, ov_a, ov_b, busy_a, busy_b;
  logic [2:0]  level_a, level_b;

  int checks = 0;
  int errors = 0;
  int seen_fe[2], seen_pe[2], seen_ov[2], exp_fe[2], exp_pe[2], exp_ov[2];
  logic [7:0] qa[$];
  logic [7:0] qb[$];
  logic [7:0] last_a = 8'h00, last_b = 8'h00;

  uart_rx_fifo #(.FIFO_DEPTH(DEPTH)) u_dut (
    .io_clk(clk), .io_rst(rst), .baud_div(baud_div), .rx_in(rx_a),
    .rx_data(data_a), .rx_valid(valid_a), .rx_ready(ready_a),
    .frame_err(fe_a), .parity_err(pe_a), .overrun(ov_a), .busy(busy_a), .fifo_level(level_a)
  );

  uart_rx_fifo #(.FIFO_DEPTH(DEPTH), .PARITY_EN(1'b1), .PARITY_ODD(1'b0)) u_par (
    .io_clk(clk), .io_rst(rst), .baud_div(baud_div), .rx_in(rx_b),
    .rx_data(data_b), .rx_valid(valid_b), .rx_ready(ready_b),
    .frame_err(fe_b), .parity_err(pe_b), .overrun(ov_b), .busy(busy_b), .fifo_level(level_b)
  );

  // each high cycle counts, so a stretched pulse shows up as an extra event
  always @(negedge clk) begin
    if (fe_a) seen_fe[0]++;
    if (pe_a) seen_pe[0]++;
    if (ov_a) seen_ov[0]++;
    if (fe_b) seen_fe[1]++;
    if (pe_b) seen_pe[1]++;
    if (ov_b) seen_ov[1]++;
  end

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drive(input bit p, input logic v);
    if (p) rx_b = v;
    else rx_a = v;
  endtask

  task automatic check_all(input bit p);
    if (!p) begin
      check("level0", level_a, qa.size());
      check("valid0", valid_a, qa.size() != 0);
      check("data0", data_a, (qa.size() != 0) ? qa[0] : last_a);
      check("busy0", busy_a, 0);
    end else begin
      check("level1", level_b, qb.size());
      check("valid1", valid_b, qb.size() != 0);
      check("data1", data_b, (qb.size() != 0) ? qb[0] : last_b);
      check("busy1", busy_b, 0);
    end
    check($sformatf("frame_err%0d", p), seen_fe[p], exp_fe[p]);
    check($sformatf("parity_err%0d", p), seen_pe[p], exp_pe[p]);
    check($sformatf("overrun%0d", p), seen_ov[p], exp_ov[p]);
  endtask

  // drives one frame on line p; abort_bit >= 0 pulses reset mid-way through that bit
  task automatic send(input bit p, input logic [7:0] d, input bit par_ok, input bit stop_ok,
                      input int abort_bit, input bit jit);
    int bl;
    int nb;
    logic [10:0] bits;
    bl = (baud_div < 16'd4) ? 4 : int'(baud_div);
    bits = '1;
    bits[0] = 1'b0;
    bits[8:1] = d;
    if (p) begin
      bits[9]  = (^d) ^ !par_ok;
      bits[10] = stop_ok;
      nb = 11;
    end else begin
      bits[9] = stop_ok;
      nb = 10;
    end
    for (int i = 0; i < nb; i++) begin
      drive(p, bits[i]);
      if (i == abort_bit) begin
        tick(bl / 2);
        rst = 1'b1;
        drive(p, 1'b1);
        tick(2);
        qa.delete();
        qb.delete();
        last_a = 8'h00;
        last_b = 8'h00;
        check_all(0);
        check_all(1);
        rst = 1'b0;
        tick(2);
        return;
      end
      tick(bl);
      if (i == 0 && jit) baud_div = 16'($urandom_range(0, 12));
    end
    if (!stop_ok) begin
      tick(2 * bl);
      check($sformatf("wait_high_busy%0d", p), p ? busy_b : busy_a, 1);
    end
    drive(p, 1'b1);
    tick(bl + 8);
    if (!stop_ok) exp_fe[p]++;
    else if (p && !par_ok) exp_pe[p]++;
    else if ((p ? qb.size() : qa.size()) == DEPTH) exp_ov[p]++;
    else if (p) qb.push_back(d);
    else qa.push_back(d);
  endtask

  task automatic drain(input bit p);
    if (p) ready_b = 1'b1;
    else ready_a = 1'b1;
    while ((p ? qb.size() : qa.size()) != 0) begin
      if (!p) begin
        check("drain_data0", data_a, qa[0]);
        check("drain_valid0", valid_a, 1);
      end else begin
        check("drain_data1", data_b, qb[0]);
        check("drain_valid1", valid_b, 1);
      end
      tick(1);
      if (!p) last_a = qa.pop_front();
      else last_b = qb.pop_front();
    end
    tick(2);
    check_all(p);
    ready_a = 1'b0;
    ready_b = 1'b0;
  endtask

  initial begin
    bit p;
    int n;
    tick(3);
    check_all(0);
    check_all(1);
    rst = 1'b0;
    tick(2);

    baud_div = 16'd4;
    send(0, 8'hAA, 1, 1, -1, 0);
    check_all(0);

    rx_a = 1'b0;
    tick(1);
    rx_a = 1'b1;
    tick(20);
    check_all(0);

    send(0, 8'h55, 1, 0, -1, 0);
    check_all(0);
    send(0, 8'h12, 1, 1, -1, 0);
    check_all(0);
    drain(0);

    for (int i = 1; i <= 5; i++) begin
      send(0, 8'(i), 1, 1, -1, 0);
      check_all(0);
    end
    drain(0);

    send(1, 8'h07, 0, 1, -1, 0);
    check_all(1);
    send(1, 8'h07, 1, 1, -1, 0);
    check_all(1);

    baud_div = 16'd7;
    send(0, 8'h3C, 1, 1, -1, 0);
    send(0, 8'h99, 1, 1, 4, 0);
    baud_div = 16'd10;
    send(0, 8'hC3, 1, 1, -1, 0);
    check_all(0);
    drain(0);

    for (int b = 0; b < 8; b++) begin
      p = b[0];
      n = $urandom_range(1, 6);
      for (int k = 0; k < n; k++) begin
        baud_div = 16'($urandom_range(0, 12));
        send(p, 8'($urandom), $urandom_range(0, 5) != 0, $urandom_range(0, 5) != 0, -1, 1);
        check_all(p);
      end
      drain(p);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
Receive front end of the USART peripheral. It consumes the asynchronous serial line driven onto the USART1_RX pin and recovers 8-bit frames using a runtime clock-per-bit divisor. Completed bytes go into a small FIFO and are presented to the bus-side register interface through a valid/ready handshake. Framing, parity and overrun conditions are reported as single-cycle pulses.

Parameters:
FIFO_DEPTH, 4, number of byte entries in the receive FIFO; must be a power of 2 and at least 2.
PARITY_EN, 0, 1 means a parity bit follows the 8 data bits.
PARITY_ODD, 0, used only when PARITY_EN=1; 1 selects odd parity, 0 selects even parity.

Ports:
io_clk  input  1  system clock.
io_rst  input  1  reset; synchronous, active-high.
baud_div  input  16  io_clk cycles per bit; values below 4 are treated as 4.
rx_in  input  1  asynchronous serial line; idles high.
rx_data  output  8  FIFO head byte.
rx_valid  output  1  FIFO not empty.
rx_ready  input  1  consumer accepts the head byte.
frame_err  output  1  one-cycle pulse: stop bit sampled low.
parity_err  output  1  one-cycle pulse: parity bit mismatch.
overrun  output  1  one-cycle pulse: a completed byte was dropped because the FIFO was full.
busy  output  1  high whenever the FSM is not in IDLE.
fifo_level  output  $clog2(FIFO_DEPTH)+1  number of occupied FIFO entries.

Behaviour:
- Reset: synchronizer stages go to 1; FSM goes to IDLE.
  - Outputs after reset: rx_data=8'h00, rx_valid=0, frame_err=0, parity_err=0, overrun=0, busy=0, fifo_level=0.
  - A reset during a frame aborts the frame; no partial byte is pushed.
- Input synchronizer: 2-FF chain on rx_in producing rx_s. All decisions use rx_s, so there is 2 cycles of latency from the pin.
- Divisor capture: on entry to START, baud_div is latched into div_q (after clamping to a minimum of 4). Changes to baud_div mid-frame do not affect the current frame.
- Bit counter: cnt counts 0..div_q-1. A bit's sample point is cnt == div_q>>1 (floor).
- FSM states: IDLE, START, DATA, PARITY, STOP, WAIT_HIGH.
  - IDLE: when rx_s=0, go to START with cnt=0.
  - START: at the sample point, rx_s=1 is treated as a glitch and the FSM returns to IDLE with no flags. rx_s=0 keeps the start bit. At cnt==div_q-1, go to DATA with bit index 0.
  - DATA: sample rx_s at each sample point into shift[idx], LSB first. After bit 7 completes its full period, go to PARITY if PARITY_EN=1, otherwise STOP.
  - PARITY: sample at the sample point. The expected value is ^shift for even parity and ~^shift for odd parity. A mismatch sets a pending parity flag. After the full period, go to STOP.
  - STOP: act at the sample point; no wait for the end of the stop bit.
    - rx_s=0: pulse frame_err, discard the byte, go to WAIT_HIGH.
    - Pending parity flag set: pulse parity_err, discard the byte, go to IDLE.
    - Otherwise: push the byte, go to IDLE.
  - WAIT_HIGH: stay until rx_s=1, then go to IDLE. This covers break conditions and prevents a false start.
- Error precedence: when both errors occur on one frame, only frame_err pulses.
- FIFO push: rx_valid and fifo_level update on the cycle after the STOP sample cycle.
- FIFO pop: occurs when rx_valid && rx_ready. rx_data shows the new head on the next cycle.
- Full FIFO:
  - Push with no pop in the same cycle: the byte is dropped, overrun pulses, and FIFO contents are unchanged.
  - Push and pop in the same cycle: both are accepted and fifo_level is unchanged.
- Empty FIFO: rx_ready is ignored; rx_data keeps its last value.
- Ordering: bytes are delivered strictly FIFO. Pointers wrap modulo FIFO_DEPTH.
- Pulse width: all error pulses are exactly 1 io_clk cycle, registered.

Test Plan:
1. baud_div=4, 8N1, send 8'hAA with 4 clocks per bit -> rx_valid rises about 40 cycles after the start edge; rx_data=8'hAA; fifo_level=1; no error pulses; busy falls after the stop sample.
2. rx_in low for 1 cycle, then high -> no START accepted (returns to IDLE at the sample point); rx_valid stays 0; no flags.
3. Send 8'h55 with the stop bit driven 0 for 3 bit times -> frame_err pulses once; FIFO is unchanged; the FSM holds in WAIT_HIGH, and the next frame 8'h12 is received correctly.
4. FIFO_DEPTH=4, rx_ready=0, send 8'h01..8'h05 -> fifo_level=4; overrun pulses once on the 5th byte. Then set rx_ready=1 -> bytes 01, 02, 03, 04 are read in order, and fifo_level returns to 0.
5. PARITY_EN=1, PARITY_ODD=0, send 8'h07 with parity bit 0 (correct value is 1) -> parity_err pulses and no push. Resend with parity 1 -> rx_data=8'h07.
6. Assert io_rst during data bit 3 of a frame -> all outputs return to their reset values. After release, a fresh 8'hC3 frame at baud_div=10 is received correctly.
